// File: rtl/display_pkg.sv
// Shared types and default geometry for the LED panel scan path.
package display_pkg;

    localparam int BITWIDTH = 8;
    localparam int COLUMNS  = 32;
    localparam int ROWS     = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DISPLAY
    } scan_state_t;

endpackage

// File: rtl/display_column_shifter.sv
// Shifts one bit plane of a row into the panel, one column per 3 cycles.
// The address is issued in FETCH, the pixel comes back during SHIFT_LO and is
// presented on panel_data together with the panel_clk rise in SHIFT_HI.
module display_column_shifter
    import display_pkg::*;
#(
    parameter int bitwidth = BITWIDTH,
    parameter int columns  = COLUMNS,
    parameter int rows     = ROWS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [$clog2(rows)-1:0]                   row,
    input  logic [$clog2(bitwidth)-1:0]               bit_sel,
    input  logic [3*bitwidth-1:0]                     pixel_data,
    output logic [$clog2(rows)+$clog2(columns)-1:0]   pixel_addr,
    output logic [2:0]                                panel_data,
    output logic                                      panel_clk,
    output logic                                      done
);

    localparam int RW = $clog2(rows);
    localparam int CW = $clog2(columns);
    localparam int BW = $clog2(bitwidth);
    localparam logic [CW-1:0] LAST_COL = CW'(columns - 1);

    scan_state_t          state;
    logic [RW-1:0]        row_q;
    logic [CW-1:0]        col;
    logic [BW-1:0]        pix_bit;
    logic [bitwidth-1:0]  r_ch, g_ch, b_ch;

    // Plane 0 carries the pixel MSB.
    assign pix_bit           = BW'(bitwidth - 1) - bit_sel;
    assign {r_ch, g_ch, b_ch} = pixel_data;

    // Combinational so the parent can enter LATCH with no gap cycle.
    assign done = (state == SHIFT_HI) && (col == LAST_COL);

    // Column walk: FETCH -> SHIFT_LO -> SHIFT_HI per column, row captured at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row_q      <= '0;
            col        <= '0;
            pixel_addr <= '0;
            panel_data <= '0;
            panel_clk  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_q      <= row;
                        col        <= '0;
                        pixel_addr <= {row, {CW{1'b0}}};
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    state <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    panel_data <= {r_ch[pix_bit], g_ch[pix_bit], b_ch[pix_bit]};
                    panel_clk  <= 1'b1;
                    state      <= SHIFT_HI;
                end
                SHIFT_HI: begin
                    panel_clk <= 1'b0;
                    if (col == LAST_COL) begin
                        col   <= '0;
                        state <= IDLE;
                    end else begin
                        col        <= col + CW'(1);
                        pixel_addr <= {row_q, col + CW'(1)};
                        state      <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/display_scan_sequencer.sv
// Row/bit-plane scan FSM for the LED panel. Shifts a plane through the
// column shifter, latches it, then hands the on-time to the pulse generator.
module display_scan_sequencer
    import display_pkg::*;
#(
    parameter int bitwidth = BITWIDTH,
    parameter int columns  = COLUMNS,
    parameter int rows     = ROWS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable,
    output logic [$clog2(rows)+$clog2(columns)-1:0]   pixel_addr,
    input  logic [3*bitwidth-1:0]                     pixel_data,
    output logic [2:0]                                panel_data,
    output logic                                      panel_clk,
    output logic                                      panel_latch,
    output logic                                      panel_blank,
    output logic [$clog2(rows)-1:0]                   row_addr,
    output logic                                      pulse_go,
    input  logic                                      pulse_complete,
    input  logic [$clog2(bitwidth)-1:0]               pulse_select,
    output logic                                      frame_done,
    output logic                                      sync_error
);

    localparam int RW = $clog2(rows);
    localparam int BW = $clog2(bitwidth);
    localparam logic [BW-1:0] LAST_BIT = BW'(bitwidth - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(rows - 1);

    scan_state_t    state;
    logic [RW-1:0]  row, row_inc, shift_row;
    logic [BW-1:0]  bit_sel;
    logic           plane_end, row_end, shift_start, shift_done;

    assign row_inc     = (row == LAST_ROW) ? '0 : row + RW'(1);
    assign plane_end   = (state == DISPLAY) && pulse_complete;
    assign row_end     = plane_end && (bit_sel == LAST_BIT);
    // Start the shifter on the same edge the FSM enters FETCH.
    assign shift_start = ((state == IDLE) && enable) || (plane_end && (!row_end || enable));
    // At a row boundary the shifter must already see the next row.
    assign shift_row   = row_end ? row_inc : row;

    display_column_shifter #(
        .bitwidth (bitwidth),
        .columns  (columns),
        .rows     (rows)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .start      (shift_start),
        .row        (shift_row),
        .bit_sel    (bit_sel),
        .pixel_data (pixel_data),
        .pixel_addr (pixel_addr),
        .panel_data (panel_data),
        .panel_clk  (panel_clk),
        .done       (shift_done)
    );

    // Plane sequencing: shift, latch, display, then next plane or next row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            bit_sel     <= '0;
            row_addr    <= '0;
            panel_latch <= 1'b0;
            panel_blank <= 1'b1;
            pulse_go    <= 1'b0;
            frame_done  <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            panel_latch <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    panel_blank <= 1'b1;
                    if (enable) state <= FETCH;
                end
                FETCH: begin
                    if (shift_done) begin
                        panel_latch <= 1'b1;
                        panel_blank <= 1'b1;
                        row_addr    <= row;
                        state       <= LATCH;
                    end
                end
                LATCH: begin
                    if (pulse_select != bit_sel) sync_error <= 1'b1;
                    pulse_go    <= 1'b1;
                    panel_blank <= 1'b0;
                    state       <= DISPLAY;
                end
                DISPLAY: begin
                    if (pulse_complete) begin
                        pulse_go    <= 1'b0;
                        panel_blank <= 1'b1;
                        if (!row_end) begin
                            bit_sel <= bit_sel + BW'(1);
                            state   <= FETCH;
                        end else begin
                            bit_sel    <= '0;
                            row        <= row_inc;
                            frame_done <= (row == LAST_ROW);
                            state      <= enable ? FETCH : IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Bench for display_scan_sequencer: frame buffer and pulse generator models,
// scoreboard of expected column bits and per-plane row/pulse length.
module tb_display_scan_sequencer;

    localparam int BW   = 8;
    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int AW   = $clog2(ROWS) + $clog2(COLS);

    logic                     clk = 1'b0;
    logic                     rst, enable, pulse_complete;
    logic [AW-1:0]            pixel_addr;
    logic [3*BW-1:0]          pixel_data;
    logic [2:0]               panel_data;
    logic                     panel_clk, panel_latch, panel_blank, pulse_go, frame_done, sync_error;
    logic [$clog2(ROWS)-1:0]  row_addr;
    logic [$clog2(BW)-1:0]    pulse_select;

    typedef struct { int row; int dur; } plane_t;

    plane_t      pq[$];
    logic [2:0]  dq[$];
    logic [23:0] fb [ROWS][COLS];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, t_fetch = -1, t_latch = 0, t_rise = 0;
    int latches = 0, planes_done = 0, fd_cnt = 0;
    int cur_dur = 0, cur_row = 0;
    int sel_ofs = 0, gsel = 0, gcnt = 0;
    bit sb_on = 1'b1;

    display_scan_sequencer #(.bitwidth(BW), .columns(COLS), .rows(ROWS)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .pixel_addr     (pixel_addr),
        .pixel_data     (pixel_data),
        .panel_data     (panel_data),
        .panel_clk      (panel_clk),
        .panel_latch    (panel_latch),
        .panel_blank    (panel_blank),
        .row_addr       (row_addr),
        .pulse_go       (pulse_go),
        .pulse_complete (pulse_complete),
        .pulse_select   (pulse_select),
        .frame_done     (frame_done),
        .sync_error     (sync_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Expected column bits and pulse length for every plane of a row.
    task automatic push_row(input int r);
        for (int b = 0; b < BW; b++) begin
            pq.push_back('{r, (255 >> b) + 1});
            for (int c = 0; c < COLS; c++)
                dq.push_back({fb[r][c][23-b], fb[r][c][15-b], fb[r][c][7-b]});
        end
    endtask

    task automatic wait_for(input int which, input int target, input int maxc, input string tag);
        int n = 0;
        int v = 0;
        forever begin
            v = (which == 0) ? latches : (which == 1) ? planes_done : fd_cnt;
            if (v >= target || n >= maxc) break;
            @(negedge clk);
            n++;
        end
        chk(tag, v >= target, 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Frame buffer: data follows the address with one cycle of latency.
    initial forever begin
        @(negedge clk);
        pixel_data = fb[pixel_addr[AW-1]][pixel_addr[1:0]];
    end

    // Pulse generator model: complete arrives (255>>bit)+1 cycles after go rises.
    initial begin
        pulse_complete = 1'b0;
        pulse_select   = '0;
        forever begin
            @(negedge clk);
            pulse_complete = 1'b0;
            if (rst) begin
                gsel = 0;
                gcnt = 0;
            end else if (pulse_go) begin
                gcnt++;
                if (gcnt == (255 >> gsel) + 2) begin
                    pulse_complete = 1'b1;
                    gcnt = 0;
                    gsel = (gsel + 1) % BW;
                end
            end
            pulse_select = 3'((gsel + sel_ofs) % BW);
        end
    end

    // Output monitor and scoreboard consumer.
    initial begin
        logic p_clk = 1'b0, p_go = 1'b0, p_fd = 1'b0;
        logic [2:0] exp_d;
        plane_t pe;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_clk = 1'b0; p_go = 1'b0; p_fd = 1'b0;
            end else begin
                if (sb_on) begin
                    if (panel_clk && !p_clk) begin
                        chk("blank_in_shift", panel_blank, 1);
                        chk("data_q_nonempty", dq.size() != 0, 1);
                        if (dq.size() != 0) begin
                            exp_d = dq.pop_front();
                            chk("panel_data", panel_data, exp_d);
                        end
                    end
                    if (panel_latch) begin
                        latches++;
                        chk("blank_at_latch", panel_blank, 1);
                        chk("plane_q_nonempty", pq.size() != 0, 1);
                        if (pq.size() != 0) begin
                            pe = pq.pop_front();
                            cur_dur = pe.dur;
                            cur_row = pe.row;
                            chk("row_addr_at_latch", row_addr, pe.row);
                        end
                        if (t_fetch >= 0) chk("latch_ofs", cyc - t_fetch, 12);
                        t_fetch = -1;
                        t_latch = cyc;
                    end
                    if (pulse_go && !p_go) begin
                        chk("go_after_latch", cyc - t_latch, 1);
                        t_rise = cyc;
                    end
                    if (!pulse_go && p_go) begin
                        chk("pulse_len", cyc - t_rise - 1, cur_dur);
                        planes_done++;
                        t_fetch = cyc;
                    end
                    if (frame_done) begin
                        fd_cnt++;
                        chk("fd_width", p_fd, 0);
                        chk("fd_on_go_fall", p_go && !pulse_go, 1);
                        chk("fd_row", cur_row, ROWS - 1);
                    end
                end
                p_clk = panel_clk; p_go = pulse_go; p_fd = frame_done;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        enable = 1'b0;
        fb[0][0] = 24'h7F_01_55; fb[0][1] = 24'h00_7F_2A;
        fb[0][2] = 24'h80_80_80; fb[0][3] = 24'h13_37_7E;
        fb[1][0] = 24'hFF_00_AA; fb[1][1] = 24'h01_80_7F;
        fb[1][2] = 24'hC3_3C_5A; fb[1][3] = 24'h00_00_FF;
        repeat (3) @(negedge clk);
        chk("rst_blank", panel_blank, 1);
        chk("rst_latch", panel_latch, 0);
        chk("rst_go", pulse_go, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_sync", sync_error, 0);
        chk("rst_row_addr", row_addr, 0);
        chk("rst_pclk", panel_clk, 0);
        chk("rst_paddr", pixel_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Row 0; enable drops during plane 3 and the row still completes.
        push_row(0);
        t_fetch = cyc + 1;
        enable = 1'b1;
        wait_for(0, 4, 2000, "wait_plane3");
        enable = 1'b0;
        wait_for(1, 8, 2000, "wait_row0_done");
        repeat (30) @(negedge clk);
        chk("a_latches", latches, 8);
        chk("a_idle_blank", panel_blank, 1);
        chk("a_idle_go", pulse_go, 0);
        chk("a_row_addr", row_addr, 0);
        chk("a_dq_left", dq.size(), 0);

        // Rows 1 then 0: frame_done on the wrap, next latch shows row 0.
        push_row(1);
        push_row(0);
        t_fetch = cyc + 1;
        enable = 1'b1;
        wait_for(2, 1, 3000, "wait_frame_done");
        enable = 1'b0;
        wait_for(1, 24, 2000, "wait_wrap_row_done");
        repeat (30) @(negedge clk);
        chk("b_fd_cnt", fd_cnt, 1);
        chk("b_latches", latches, 24);
        chk("b_sync", sync_error, 0);
        chk("b_row_addr", row_addr, 0);
        chk("b_blank", panel_blank, 1);
        chk("b_pq_left", pq.size(), 0);

        // Asynchronous reset in the middle of a DISPLAY phase.
        push_row(1);
        t_fetch = cyc + 1;
        enable = 1'b1;
        n = 0;
        while (!pulse_go && n < 200) begin @(negedge clk); n++; end
        chk("c_go_seen", pulse_go, 1);
        chk("c_row_addr_pre", row_addr, 1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("c_async_blank", panel_blank, 1);
        chk("c_async_go", pulse_go, 0);
        enable = 1'b0;
        pq.delete();
        dq.delete();
        t_fetch = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("c_row_addr", row_addr, 0);
        chk("c_fd", frame_done, 0);
        chk("c_sync", sync_error, 0);

        // Generator out of step: select 3 while the sequencer is on plane 0.
        sb_on = 1'b0;
        sel_ofs = 3;
        enable = 1'b1;
        n = 0;
        while (!panel_latch && n < 200) begin @(negedge clk); n++; end
        chk("d_latch_seen", panel_latch, 1);
        chk("d_sel_at_latch", pulse_select, 3);
        chk("d_sync_before", sync_error, 0);
        @(negedge clk);
        chk("d_sync_set", sync_error, 1);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        chk("d_sync_sticky", sync_error, 1);
        rst = 1'b1;
        #1;
        chk("d_sync_cleared", sync_error, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
